// File: rtl/data_ram_responder.sv
// Responder side of the MEM-stage RAM request interface: word-wide data RAM with
// byte lanes, configurable wait states and a store-only console byte port.
module data_ram_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_0104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_valid,
    input  logic        ram_write,
    input  logic [3:0]  ram_byte,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        ram_ready,
    output logic        ram_err,
    output logic        con_valid,
    output logic [7:0]  con_data
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_WAIT    = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        con_valid_q;
    logic [7:0]  con_data_q;

    logic [31:0] mem [DEPTH];

    // With zero wait states the commit edge is the accept edge, so the live
    // inputs are used in IDLE and the latched copy everywhere else.
    logic        idle;
    logic        req_wr;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    assign idle      = (state_q == S_IDLE);
    assign req_wr    = idle ? ram_write  : wr_q;
    assign req_be    = idle ? ram_byte   : be_q;
    assign req_addr  = idle ? ram_addr   : addr_q;
    assign req_wdata = idle ? ram_data_i : wdata_q;

    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  mask_ok;
    logic                  misalign;
    logic                  is_console;
    logic                  out_of_range;
    logic                  req_err;

    assign off          = req_addr[1:0];
    assign word_idx     = req_addr[ADDR_WIDTH+1:2];
    assign mask_ok      = (req_be == 4'b0001) || (req_be == 4'b0011) || (req_be == 4'b1111);
    assign misalign     = !mask_ok
                        || ((req_be == 4'b0011) && off[0])
                        || ((req_be == 4'b1111) && (off != 2'b00));
    assign is_console   = (req_addr == CONSOLE_ADDR);
    assign out_of_range = ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) && !is_console;
    assign req_err      = misalign || out_of_range;

    logic commit;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ram_valid) begin
                    cnt_d = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!ram_valid) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic [31:0] rd_word;
    logic [31:0] size_mask;
    logic [31:0] load_val;
    logic        load_commit;
    logic        con_commit;
    logic        mem_we;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    assign rd_word     = mem[word_idx];
    assign size_mask   = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
    assign load_val    = (rd_word >> {off, 3'b000}) & size_mask;
    assign load_commit = commit && !req_wr;
    assign con_commit  = commit && req_wr && is_console && !req_err;
    assign mem_we      = commit && rst && req_wr && is_console == 1'b0 && !req_err;
    assign wr_be       = req_be << off;
    assign wr_data     = req_wdata << {off, 3'b000};

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            be_q        <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            con_valid_q <= 1'b0;
            con_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= commit;
            err_q       <= commit && req_err;
            con_valid_q <= con_commit;
            if (idle && ram_valid) begin
                wr_q    <= ram_write;
                be_q    <= ram_byte;
                addr_q  <= ram_addr;
                wdata_q <= ram_data_i;
            end
            if (con_commit) begin
                con_data_q <= req_wdata[7:0];
            end
            if (load_commit) begin
                rdata_q <= (req_err || is_console) ? 32'd0 : load_val;
            end
        end
    end

    // NOTE: the RAM array has no reset; contents survive rst and the array maps
    // onto plain storage.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign ram_data_o = rdata_q;
    assign ram_ready  = ready_q;
    assign ram_err    = err_q;
    assign con_valid  = con_valid_q;
    assign con_data   = con_data_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) driven by a linear
// sequence of requests with hand-computed expected results.
module tb_data_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v   [3];
    logic        w   [3];
    logic [3:0]  be  [3];
    logic [31:0] a   [3];
    logic [31:0] wd  [3];
    logic [31:0] rd  [3];
    logic        rdy [3];
    logic        er  [3];
    logic        cv  [3];
    logic [7:0]  cd  [3];

    int tests = 0;
    int fails = 0;

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .CONSOLE_ADDR(32'h104)) u_w0 (
        .clk(clk), .rst(rst_n), .ram_valid(v[0]), .ram_write(w[0]), .ram_byte(be[0]),
        .ram_addr(a[0]), .ram_data_i(wd[0]), .ram_data_o(rd[0]), .ram_ready(rdy[0]),
        .ram_err(er[0]), .con_valid(cv[0]), .con_data(cd[0]));

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .CONSOLE_ADDR(32'h104)) u_w1 (
        .clk(clk), .rst(rst_n), .ram_valid(v[1]), .ram_write(w[1]), .ram_byte(be[1]),
        .ram_addr(a[1]), .ram_data_i(wd[1]), .ram_data_o(rd[1]), .ram_ready(rdy[1]),
        .ram_err(er[1]), .con_valid(cv[1]), .con_data(cd[1]));

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .CONSOLE_ADDR(32'h104)) u_w3 (
        .clk(clk), .rst(rst_n), .ram_valid(v[2]), .ram_write(w[2]), .ram_byte(be[2]),
        .ram_addr(a[2]), .ram_data_i(wd[2]), .ram_data_o(rd[2]), .ram_ready(rdy[2]),
        .ram_err(er[2]), .con_valid(cv[2]), .con_data(cd[2]));

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request on responder d and check handshake, latency, err, load data
    // and console pulse; exp_rd is the expected ram_data_o after completion.
    task automatic req(input int d, input bit wr, input logic [3:0] bm, input logic [31:0] ad,
                       input logic [31:0] dat, input bit exp_err, input logic [31:0] exp_rd,
                       input bit exp_con, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        v[d] = 1'b1; w[d] = wr; be[d] = bm; a[d] = ad; wd[d] = dat;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy[d]) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, " ready"},   32'(seen),    32'd1);
        check({tag, " latency"}, 32'(lat),     32'(wait_of(d) + 1));
        check({tag, " err"},     32'(er[d]),   32'(exp_err));
        check({tag, " data"},    rd[d],        exp_rd);
        check({tag, " con"},     32'(cv[d]),   32'(exp_con));
        v[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " ready drop"}, 32'(rdy[d]), 32'd0);
        check({tag, " con drop"},   32'(cv[d]),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; w[i] = 1'b0; be[i] = 4'd0; a[i] = 32'd0; wd[i] = 32'd0;
        end
        #12;
        check("reset ready", 32'(rdy[1]), 32'd0);
        check("reset err",   32'(er[1]),  32'd0);
        check("reset data",  rd[1],       32'd0);
        check("reset con_v", 32'(cv[1]),  32'd0);
        check("reset con_d", 32'(cd[1]),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // One wait state: basic stores, loads and byte lanes.
        req(1, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, "sw 0x10");
        req(1, 1'b0, 4'b1111, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, "lw 0x10");
        req(1, 1'b1, 4'b0001, 32'h12, 32'h00000055, 1'b0, 32'hDEADBEEF, 1'b0, "sb 0x12");
        req(1, 1'b0, 4'b1111, 32'h10, 32'h0,        1'b0, 32'hDE55BEEF, 1'b0, "lw after sb");
        req(1, 1'b0, 4'b0001, 32'h13, 32'h0,        1'b0, 32'h000000DE, 1'b0, "lb 0x13");
        req(1, 1'b0, 4'b0011, 32'h12, 32'h0,        1'b0, 32'h0000DE55, 1'b0, "lh 0x12");

        // Error cases: misaligned, out of range, illegal mask.
        req(1, 1'b1, 4'b0011, 32'h11, 32'h00001234, 1'b1, 32'h0000DE55, 1'b0, "sh misaligned");
        req(1, 1'b0, 4'b1111, 32'h10, 32'h0,        1'b0, 32'hDE55BEEF, 1'b0, "lw unchanged");
        req(1, 1'b0, 4'b1111, 32'h00100000, 32'h0,  1'b1, 32'h0,        1'b0, "lw out of range");
        req(1, 1'b0, 4'b1111, 32'h10, 32'h0,        1'b0, 32'hDE55BEEF, 1'b0, "lw reload");
        req(1, 1'b0, 4'b1111, 32'h12, 32'h0,        1'b1, 32'h0,        1'b0, "lw misaligned");
        req(1, 1'b0, 4'b0011, 32'h10, 32'h0,        1'b0, 32'h0000BEEF, 1'b0, "lh 0x10");
        req(1, 1'b0, 4'b0111, 32'h10, 32'h0,        1'b1, 32'h0,        1'b0, "bad mask");

        // Console byte port.
        req(1, 1'b1, 4'b0001, 32'h104, 32'hAAAAAA41, 1'b0, 32'h0,       1'b1, "console sb");
        check("console byte", 32'(cd[1]), 32'h41);
        req(1, 1'b0, 4'b1111, 32'h10,  32'h0,       1'b0, 32'hDE55BEEF, 1'b0, "lw pre console");
        req(1, 1'b0, 4'b1111, 32'h104, 32'h0,       1'b0, 32'h0,        1'b0, "lw console");

        // Reset in the middle of a store's wait state.
        req(1, 1'b1, 4'b1111, 32'h20, 32'h13579BDF, 1'b0, 32'h0,        1'b0, "sw 0x20");
        req(1, 1'b0, 4'b1111, 32'h10, 32'h0,        1'b0, 32'hDE55BEEF, 1'b0, "lw pre reset");
        @(negedge clk);
        v[1] = 1'b1; w[1] = 1'b1; be[1] = 4'b1111; a[1] = 32'h20; wd[1] = 32'hFFFFFFFF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset ready", 32'(rdy[1]), 32'd0);
        check("midreset err",   32'(er[1]),  32'd0);
        check("midreset data",  rd[1],       32'd0);
        check("midreset con_v", 32'(cv[1]),  32'd0);
        check("midreset con_d", 32'(cd[1]),  32'd0);
        @(negedge clk);
        v[1] = 1'b0;
        rst_n = 1'b1;
        req(1, 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0, 32'h13579BDF, 1'b0, "lw 0x20 after reset");
        req(1, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, 32'hDE55BEEF, 1'b0, "lw 0x10 after reset");

        // Zero wait states: back-to-back loads complete every second cycle.
        req(0, 1'b1, 4'b1111, 32'h40, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, "w0 sw 0x40");
        @(negedge clk);
        v[0] = 1'b1; w[0] = 1'b0; be[0] = 4'b1111; a[0] = 32'h40; wd[0] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("w0 b2b ready %0d", i), 32'(rdy[0]), 32'((i % 2) == 0));
        end
        check("w0 b2b data", rd[0], 32'h0BADF00D);
        v[0] = 1'b0;

        // Three wait states: dropping ram_valid in WAIT aborts without commit.
        req(2, 1'b1, 4'b1111, 32'h8, 32'h11112222, 1'b0, 32'h0, 1'b0, "w3 sw 0x8");
        @(negedge clk);
        v[2] = 1'b1; w[2] = 1'b1; be[2] = 4'b1111; a[2] = 32'h8; wd[2] = 32'h99999999;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        v[2] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy[2]) pulses++;
        end
        check("w3 abort no ready", 32'(pulses), 32'd0);
        req(2, 1'b0, 4'b1111, 32'h8, 32'h0, 1'b0, 32'h11112222, 1'b0, "w3 lw after abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the MEM-stage RAM request interface: accepts valid/write/byte-mask/address/store-data requests and returns load data plus a completion handshake.
- Holds the data RAM with configurable wait states and a memory-mapped console byte port.
- Sits between the MEM stage and storage; the MEM stage stalls the pipeline until ram_ready.

Parameters:
ADDR_WIDTH, 10, word-address bits (RAM = 2^ADDR_WIDTH 32-bit words)
WAIT_CYCLES, 1, extra wait cycles between accept and completion (0..15)
CONSOLE_ADDR, 32'h00000104, store-only console byte address

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
ram_valid  in  1  request present; held stable until ram_ready
ram_write  in  1  1 = store, 0 = load
ram_byte  in  4  size mask: 0001 byte, 0011 half, 1111 word (lane-0 justified)
ram_addr  in  32  byte address
ram_data_i  in  32  store data, lane-0 justified
ram_data_o  out  32  load data, lane-0 justified (right-shifted by addr[1:0])
ram_ready  out  1  one-cycle completion pulse
ram_err  out  1  with ram_ready: misaligned or out-of-range access
con_valid  out  1  one-cycle pulse: console byte written
con_data  out  8  console byte

Behaviour:
- Reset (rst=0, async): state IDLE; ram_ready=0, ram_err=0, ram_data_o=0, con_valid=0, con_data=0, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE with ram_valid=1: latch write/byte/addr/data and load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else DONE.
- WAIT: counter decrements each cycle; at counter==1, go to DONE.
- WAIT with ram_valid=0: abort to IDLE, no commit, no ready.
- Commit happens on the clock edge entering DONE:
  - Store: write bytes enabled by (ram_byte << addr[1:0]) with data (ram_data_i << 8*addr[1:0]).
  - Load: ram_data_o = word >> 8*addr[1:0], masked to the requested size. Unused upper bytes are 0; the initiator does sign extension.
- DONE: ram_ready=1 (and ram_err if flagged) for exactly one cycle, then IDLE. A new request can be accepted the following cycle.
- Latency from accept edge to ready high: WAIT_CYCLES+1 cycles. Throughput: one request per WAIT_CYCLES+2 cycles.
- ram_data_o holds its value until the next load completes. Stores leave it unchanged.
- Misaligned requests flag ram_err at DONE; stores write nothing, loads return 0:
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - any mask other than 0001/0011/1111
- Out of range: addr[31:ADDR_WIDTH+2]≠0 and addr≠CONSOLE_ADDR → err, no write, load returns 0.
- Console:
  - Store to CONSOLE_ADDR (any size): no RAM write; con_data=ram_data_i[7:0]; con_valid=1 in the DONE cycle only; no err.
  - Load from CONSOLE_ADDR returns 0, no err.
- Reset during WAIT/DONE: immediate return to IDLE; an uncommitted store is dropped; ready and con_valid deasserted.
- No pipelining: request inputs are ignored outside IDLE (sampled only at accept).

Test Plan:
- WAIT_CYCLES=1: sw 0xDEADBEEF to 0x10, then lw 0x10 → ram_data_o=0xDEADBEEF; ready high 2 cycles after each accept edge; err=0.
- After the above, sb 0x55 to 0x12 then lw 0x10 → 0xDE55BEEF. lb 0x13 → ram_data_o=0x000000DE. lh 0x12 → 0x0000DE55.
- sh 0x1234 to 0x11 → ram_err=1 with ready, memory unchanged (lw 0x10 still 0xDE55BEEF). lw from 0x00100000 (ADDR_WIDTH=10) → err=1, data 0.
- sb 0x41 to 0x104 → con_valid one cycle, con_data=0x41; RAM word 0x104 unchanged; err=0.
- Assert rst=0 mid-WAIT of sw 0xFFFFFFFF to 0x20 → outputs zero immediately; after release, lw 0x20 returns the prior contents.
- WAIT_CYCLES=0: back-to-back lw requests → ready every 2nd cycle. Drop ram_valid in WAIT (WAIT_CYCLES=3) → no ready pulse, FSM returns to IDLE.
